branch_flush_ctrl: RTL
======================

Name: branch_flush_ctrl

Overview:
Sequences control-flow redirects for the dual-issue 8-bit core. Consumes per-lane branch outcomes (lane 1 older, lane 2 younger) plus targets and picks the winning redirect. Kills the younger lane when the older one branches and holds fetch and front-end flush for a fixed number of cycles. Sits between the branch unit outputs and the fetch/PC and pipeline-register control.

Parameters:
PC_W, 8, width of PC and branch targets
FLUSH_CYCLES, 2, cycles flush/fetch_hold stay asserted after a redirect (legal range 1..15)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  pipeline stall; branch inputs not consumed while high
valid1  in  1  lane-1 instruction valid in EX
valid2  in  1  lane-2 instruction valid in EX
is_br1  in  1  lane-1 is a conditional branch
is_br2  in  1  lane-2 is a conditional branch
taken1  in  1  lane-1 branch condition result
taken2  in  1  lane-2 branch condition result
target1  in  PC_W  lane-1 branch target
target2  in  PC_W  lane-2 branch target
redirect  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  PC_W  target being redirected to; held until next redirect
squash2  out  1  one-cycle pulse: kill lane-2 result (no writeback)
flush  out  1  invalidate IF/ID contents while high
fetch_hold  out  1  suppress PC increment while high
busy  out  1  state != IDLE
br_cnt1  out  8  lane-1 taken-branch count (see Optional Feature)
br_cnt2  out  8  lane-2 taken-branch count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0; redirect_pc = 0; state = IDLE; counter = 0.
- All outputs are registered. Latency from a qualifying input edge to redirect/squash2/flush is 1 cycle.
- Qualifiers: take1 = valid1 & is_br1 & taken1; take2 = valid2 & is_br2 & taken2.
- FSM states: IDLE, FLUSH.
- IDLE, stall=1: inputs ignored, no outputs asserted.
- IDLE, stall=0, take1:
  - redirect_pc <= target1; redirect <= 1; squash2 <= 1, even if lane 2 is not a branch or is invalid.
  - cnt <= FLUSH_CYCLES-1; flush <= 1; fetch_hold <= 1; go to FLUSH.
- IDLE, stall=0, !take1 & take2: same as above with target2, but squash2 <= 0.
- Simultaneous take1 and take2: lane 1 wins. target2 is discarded and squash2 = 1.
- IDLE otherwise: stay in IDLE; pulses deassert.
- FLUSH:
  - redirect and squash2 are 0 after their single cycle. flush = fetch_hold = 1.
  - If cnt == 0: next cycle flush = fetch_hold = 0, go to IDLE. Else cnt decrements.
  - Total flush high time is exactly FLUSH_CYCLES cycles.
  - All branch inputs are ignored in FLUSH, including take1/take2 (they are wrong-path).
  - stall does not freeze the counter.
- Back-to-back: a branch in the first IDLE cycle after FLUSH is accepted normally.
- rst mid-FLUSH: next cycle IDLE with all outputs 0. A pending squash is dropped.
- busy = (state == FLUSH), registered.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: br_cnt1/br_cnt2 increment on each accepted take1/take2 redirect. Lane-2 increments only when lane 2 actually redirects. Counters saturate at 255 and reset to 0 on rst.
- Undefined: ports remain present, tied to 0, no counter flops.

Decomposition:
- Package branch_ctrl_pkg: state enum (IDLE, FLUSH), PC_W default constant, FLUSH counter width constant (4 bits).
- One natural sub-module: sat_counter8, an 8-bit saturating incrementer with sync reset. It is instantiated twice, only under BRANCH_STATS_EN.

Test Plan:
- Reset: rst=1 for 2 cycles with take1 stimulus active -> all outputs 0, busy=0, redirect_pc=0x00.
- Lane-1 only: valid1=1, is_br1=1, taken1=1, target1=0x3C, stall=0 -> next cycle redirect=1, squash2=1, redirect_pc=0x3C, flush high exactly 2 cycles, then IDLE.
- Both taken: target1=0x10, target2=0x80 -> redirect_pc=0x10, squash2=1, one redirect pulse only. br_cnt1=1, br_cnt2=0 with BRANCH_STATS_EN.
- Lane-2 only: taken2=1, target2=0xF0, valid1=1 non-branch -> redirect_pc=0xF0, squash2=0. Then stall=1 with take1 in IDLE -> no redirect.
- Branch during FLUSH: take1 with target1=0x55 in second flush cycle -> ignored, redirect_pc unchanged. Then rst asserted mid-FLUSH -> IDLE next cycle, flush=0.
- Saturation (BRANCH_STATS_EN): 260 spaced lane-1 redirects -> br_cnt1=255. Macro undefined -> br_cnt1=br_cnt2=0 throughout.

Source files
------------

// File: rtl/branch_flush_ctrl_pkg.sv
// Shared types and constants for the branch redirect / front-end flush controller.
package branch_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int unsigned PC_W_DEF = 8;
    localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// Branch-unit to fetch/pipeline-control bundle; master drives branch outcomes, slave is the controller.
interface branch_flush_ctrl_if
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
);
    logic            stall;
    logic            valid1;
    logic            valid2;
    logic            is_br1;
    logic            is_br2;
    logic            taken1;
    logic            taken2;
    logic [PC_W-1:0] target1;
    logic [PC_W-1:0] target2;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            squash2;
    logic            flush;
    logic            fetch_hold;
    logic            busy;
    logic [7:0]      br_cnt1;
    logic [7:0]      br_cnt2;

    modport master (
        output stall, valid1, valid2, is_br1, is_br2, taken1, taken2, target1, target2,
        input  redirect, redirect_pc, squash2, flush, fetch_hold, busy, br_cnt1, br_cnt2
    );

    modport slave (
        input  stall, valid1, valid2, is_br1, is_br2, taken1, taken2, target1, target2,
        output redirect, redirect_pc, squash2, flush, fetch_hold, busy, br_cnt1, br_cnt2
    );
endinterface

// File: rtl/branch_flush_ctrl_sat_counter8.sv
// 8-bit saturating event counter with synchronous active-high reset.
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/branch_flush_ctrl.sv
// Picks the winning lane redirect, squashes lane 2 behind a lane-1 branch, holds fetch/flush afterwards.
// Optional taken-branch statistics enabled by defining BRANCH_STATS_EN.
module branch_flush_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = PC_W_DEF,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_flush_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_redirect;
    logic [PC_W-1:0] r_redirect_pc;
    logic            r_squash2;
    logic            r_flush;
    logic            r_fetch_hold;
    logic            r_busy;

    state_t          w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic            w_redirect_nx;
    logic [PC_W-1:0] w_pc_nx;
    logic            w_squash2_nx;
    logic            w_flush_nx;
    logic            w_take1;
    logic            w_take2;

    assign w_take1 = bus.valid1 & bus.is_br1 & bus.taken1;
    assign w_take2 = bus.valid2 & bus.is_br2 & bus.taken2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_squash2     <= 1'b0;
            r_flush       <= 1'b0;
            r_fetch_hold  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_redirect    <= w_redirect_nx;
            r_redirect_pc <= w_pc_nx;
            r_squash2     <= w_squash2_nx;
            r_flush       <= w_flush_nx;
            r_fetch_hold  <= w_flush_nx;
            r_busy        <= (w_state_nx == FLUSH);
        end
    end

    // Lane 1 is older, so it wins a tie and its branch kills whatever lane 2 produced.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_redirect_nx = 1'b0;
        w_pc_nx       = r_redirect_pc;
        w_squash2_nx  = 1'b0;
        w_flush_nx    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.stall && (w_take1 || w_take2)) begin
                    w_redirect_nx = 1'b1;
                    w_squash2_nx  = w_take1;
                    w_pc_nx       = w_take1 ? bus.target1 : bus.target2;
                    w_cnt_nx      = FLUSH_LOAD;
                    w_flush_nx    = 1'b1;
                    w_state_nx    = FLUSH;
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx   = r_cnt - 1'b1;
                    w_flush_nx = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.squash2     = r_squash2;
    assign bus.flush       = r_flush;
    assign bus.fetch_hold  = r_fetch_hold;
    assign bus.busy        = r_busy;

`ifdef BRANCH_STATS_EN
    logic w_acc1;
    logic w_acc2;

    assign w_acc1 = (r_state == IDLE) & ~bus.stall & w_take1;
    assign w_acc2 = (r_state == IDLE) & ~bus.stall & ~w_take1 & w_take2;

    sat_counter8 u_br_cnt1 (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_acc1),
        .o_cnt (bus.br_cnt1)
    );

    sat_counter8 u_br_cnt2 (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_acc2),
        .o_cnt (bus.br_cnt2)
    );
`else
    assign bus.br_cnt1 = '0;
    assign bus.br_cnt2 = '0;
`endif

endmodule
